// File: rtl/scl_clock_gen.sv
// -----------------------------------------------------------------------------
// scl_clock_gen
//   I2C SCL waveform generator. A free-running phase counter defines one SCL
//   period of COUNTER_END clk_in cycles: LOW for counter 0..COUNTER_RISE-1,
//   released for the rest. The same counter is exported so the bit-level
//   master can place SDA shift/sample points at fixed phases.
//
//   The line is open-drain by default (drive 0 or high-Z). On top of the basic
//   period it supports:
//     - slave clock stretching: the counter parks at COUNTER_RISE until the
//       line is actually seen HIGH, so the HIGH phase is always full length;
//     - multi-master synchronisation: another master pulling SCL LOW during
//       our HIGH phase restarts our period at 0;
//     - stuck-LOW detection: bus_clear rises once the line has been held LOW
//       for WAIT_END consecutive cycles while we are releasing it.
//   With PUSH_PULL=1 the HIGH phase is actively driven, so the read-back can
//   never show a foreign LOW and the stretching/multi-master rules are off.
// -----------------------------------------------------------------------------
module scl_clock_gen #(
  parameter int COUNTER_END      = 500,
  parameter int COUNTER_RISE     = 250,
  parameter bit MULTI_MASTER     = 1'b0,
  parameter bit CLOCK_STRETCHING = 1'b1,
  parameter int WAIT_END         = 1000000,
  parameter bit PUSH_PULL        = 1'b0,
  localparam int CW              = $clog2(COUNTER_END),
  localparam int WW              = $clog2(WAIT_END + 1)
) (
  input  logic          clk_in,
  input  logic          reset,
  inout  wire           scl,
  output logic          bus_clear,
  output logic [CW-1:0] counter
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter sanity. The LOW phase must be non-empty and the
  // HIGH phase must span at least two counts so that "counter > COUNTER_RISE"
  // (multi-master window) is reachable.
  // ---------------------------------------------------------------------------
  if (COUNTER_END < 4 || COUNTER_RISE <= 0 || COUNTER_RISE >= COUNTER_END - 1 ||
      WAIT_END < 1) begin : g_bad_params
    $error("scl_clock_gen: illegal COUNTER_END/COUNTER_RISE/WAIT_END combination");
  end

  // Effective feature enables: push-pull drives the HIGH phase itself, so the
  // read-back is always 1 and the line-sensing rules must not act.
  localparam bit MM_EN = MULTI_MASTER     && !PUSH_PULL;
  localparam bit CS_EN = CLOCK_STRETCHING && !PUSH_PULL;

  localparam logic [CW-1:0] CNT_RISE = CW'(COUNTER_RISE);
  localparam logic [CW-1:0] CNT_LAST = CW'(COUNTER_END - 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(WAIT_END);

  // ---------------------------------------------------------------------------
  // Internal state and decode
  // ---------------------------------------------------------------------------
  logic [WW-1:0] wait_cnt;
  logic [WW-1:0] wait_next;
  logic [CW-1:0] counter_next;
  logic          bus_clear_next;

  logic          released;    // we are not pulling the line LOW this cycle
  logic          drive_low;   // open-drain pull-down enable
  logic          scl_low;     // resolved line level as seen by this master
  logic          mm_restart;  // another master cut our HIGH phase short
  logic          stretching;  // a slave is holding SCL LOW at our rise point

  assign released   = (counter >= CNT_RISE);
  assign scl_low    = (scl == 1'b0);
  assign mm_restart = MM_EN && (counter > CNT_RISE) && scl_low;
  assign stretching = CS_EN && (counter == CNT_RISE) && scl_low;

  // Reset forces the pad to its released state regardless of the counter,
  // so the bus is never pulled LOW while the block is being reset.
  assign drive_low  = !reset && !released;

  // Pad driver: 0 in the LOW phase; high-Z (or a driven 1 for push-pull)
  // otherwise. The external pull-up supplies the HIGH level in open-drain mode.
  assign scl = drive_low ? 1'b0 : (PUSH_PULL ? 1'b1 : 1'bz);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------

  // Phase counter: multi-master restart beats stretching, which beats wrap.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default on entry;
    // an output left unassigned on some path would otherwise infer a latch.
    counter_next = counter + CW'(1);
    if (mm_restart) begin
      counter_next = '0;
    end else if (stretching) begin
      counter_next = counter;
    end else if (counter == CNT_LAST) begin
      counter_next = '0;
    end
  end

  // Stuck-LOW timer: counts consecutive released-but-LOW samples, saturating.
  // A multi-master restart means we start driving LOW ourselves, so the
  // observation is no longer "stuck" and the timer restarts.
  always_comb begin
    wait_next = '0;
    if (released && scl_low && !mm_restart) begin
      if (wait_cnt != WAIT_MAX) begin
        wait_next = wait_cnt + WW'(1);
      end else begin
        wait_next = wait_cnt;
      end
    end
  end

  // bus_clear level: sets one edge after the timer has saturated, clears on
  // the first edge the line reads HIGH, otherwise holds.
  always_comb begin
    bus_clear_next = bus_clear;
    if (!scl_low) begin
      bus_clear_next = 1'b0;
    end else if (wait_cnt == WAIT_MAX) begin
      bus_clear_next = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers with synchronous active-high reset
  // ---------------------------------------------------------------------------

  // Register phase counter, stuck-LOW timer and bus_clear flag.
  always_ff @(posedge clk_in) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      counter   <= '0;
      wait_cnt  <= '0;
      bus_clear <= 1'b0;
    end else begin
      counter   <= counter_next;
      wait_cnt  <= wait_next;
      bus_clear <= bus_clear_next;
    end
  end

endmodule

// File: tb/tb_scl_clock_gen.sv
// -----------------------------------------------------------------------------
// tb_scl_clock_gen
//   Four instances with COUNTER_END=8, COUNTER_RISE=4, WAIT_END=20:
//     u_a : stretching on,  multi-master off  (default open-drain)
//     u_b : stretching off, multi-master off
//     u_c : stretching on,  multi-master on
//     u_d : push-pull
//   Open-drain lines carry a pull-up; the push-pull line has none, so only an
//   actively driven 1 reads back as 1 during its HIGH phase.
// -----------------------------------------------------------------------------
module tb_scl_clock_gen;

  localparam int CE = 8;
  localparam int CR = 4;
  localparam int WE = 20;

  logic       clk_in = 1'b0;
  logic       reset  = 1'b1;
  logic       ext_a  = 1'b0;
  logic       ext_b  = 1'b0;
  logic       ext_c  = 1'b0;
  logic       ext_d  = 1'b0;

  wire        scl_a, scl_b, scl_c, scl_d;
  logic       bc_a, bc_b, bc_c, bc_d;
  logic [2:0] cnt_a, cnt_b, cnt_c, cnt_d;

  // External open-drain agents (slave / other master)
  pullup (scl_a);
  pullup (scl_b);
  pullup (scl_c);
  assign scl_a = ext_a ? 1'b0 : 1'bz;
  assign scl_b = ext_b ? 1'b0 : 1'bz;
  assign scl_c = ext_c ? 1'b0 : 1'bz;
  assign scl_d = ext_d ? 1'b0 : 1'bz;

  always #5 clk_in = ~clk_in;

  scl_clock_gen #(.COUNTER_END(CE), .COUNTER_RISE(CR), .MULTI_MASTER(1'b0),
                  .CLOCK_STRETCHING(1'b1), .WAIT_END(WE), .PUSH_PULL(1'b0))
    u_a (.clk_in(clk_in), .reset(reset), .scl(scl_a), .bus_clear(bc_a), .counter(cnt_a));

  scl_clock_gen #(.COUNTER_END(CE), .COUNTER_RISE(CR), .MULTI_MASTER(1'b0),
                  .CLOCK_STRETCHING(1'b0), .WAIT_END(WE), .PUSH_PULL(1'b0))
    u_b (.clk_in(clk_in), .reset(reset), .scl(scl_b), .bus_clear(bc_b), .counter(cnt_b));

  scl_clock_gen #(.COUNTER_END(CE), .COUNTER_RISE(CR), .MULTI_MASTER(1'b1),
                  .CLOCK_STRETCHING(1'b1), .WAIT_END(WE), .PUSH_PULL(1'b0))
    u_c (.clk_in(clk_in), .reset(reset), .scl(scl_c), .bus_clear(bc_c), .counter(cnt_c));

  scl_clock_gen #(.COUNTER_END(CE), .COUNTER_RISE(CR), .MULTI_MASTER(1'b0),
                  .CLOCK_STRETCHING(1'b0), .WAIT_END(WE), .PUSH_PULL(1'b1))
    u_d (.clk_in(clk_in), .reset(reset), .scl(scl_d), .bus_clear(bc_d), .counter(cnt_d));

  // ---------------------------------------------------------------------------
  // Vector table: ext is applied before the edge, cnt/bc are expected after it
  // ---------------------------------------------------------------------------
  typedef struct {
    logic       ext;
    logic [2:0] cnt;
    logic       bc;
  } vec_t;

  vec_t vq[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [2:0] get_cnt(input int u);
    case (u)
      0:       return cnt_a;
      1:       return cnt_b;
      2:       return cnt_c;
      default: return cnt_d;
    endcase
  endfunction

  function automatic logic get_bc(input int u);
    case (u)
      0:       return bc_a;
      1:       return bc_b;
      2:       return bc_c;
      default: return bc_d;
    endcase
  endfunction

  task automatic set_ext(input int u, input logic v);
    case (u)
      0:       ext_a = v;
      1:       ext_b = v;
      2:       ext_c = v;
      default: ext_d = v;
    endcase
  endtask

  task automatic add(input logic e, input int c, input logic b);
    vec_t v;
    v.ext = e;
    v.cnt = c[2:0];
    v.bc  = b;
    vq.push_back(v);
  endtask

  task automatic add_n(input int n, input logic e, input int c, input logic b);
    for (int i = 0; i < n; i++) add(e, c, b);
  endtask

  task automatic apply(input int u, input string tag);
    foreach (vq[i]) begin
      set_ext(u, vq[i].ext);
      tick();
      check($sformatf("%s[%0d].cnt", tag, i), 32'(get_cnt(u)), 32'(vq[i].cnt));
      check($sformatf("%s[%0d].bc", tag, i), 32'(get_bc(u)), 32'(vq[i].bc));
    end
    set_ext(u, 1'b0);
    vq.delete();
  endtask

  // Advance until instance u shows counter value t, bounded.
  task automatic wait_cnt(input int u, input int t);
    int n = 0;
    while (get_cnt(u) != 3'(t) && n < 4 * CE) begin
      tick();
      n++;
    end
    if (get_cnt(u) != 3'(t)) begin
      tests++;
      fails++;
      $display("FAIL wait_cnt u%0d: got %0d expected %0d", u, get_cnt(u), t);
    end
  endtask

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // ---------------- reset state ----------------
    reset = 1'b1;
    tick();
    tick();
    check("rst.cnt_a", 32'(cnt_a), 0);
    check("rst.cnt_c", 32'(cnt_c), 0);
    check("rst.cnt_d", 32'(cnt_d), 0);
    check("rst.bc_a",  32'(bc_a), 0);
    check("rst.scl_a", 32'(scl_a), 1);
    check("rst.scl_d", 32'(scl_d), 1);
    reset = 1'b0;
    #1;
    check("post_rst.cnt_a", 32'(cnt_a), 0);
    check("post_rst.scl_a", 32'(scl_a), 0);
    check("post_rst.scl_d", 32'(scl_d), 0);

    // ---------------- free run: 0..7,0.. ; scl low 0-3, high 4-7 ----------------
    for (int i = 0; i < 2 * CE; i++) begin
      int exp_c;
      tick();
      exp_c = (i + 1) % CE;
      check($sformatf("free.cnt_a[%0d]", i), 32'(cnt_a), 32'(exp_c));
      check($sformatf("free.scl_a[%0d]", i), 32'(scl_a), 32'(exp_c >= CR));
      check($sformatf("free.cnt_d[%0d]", i), 32'(cnt_d), 32'(exp_c));
      check($sformatf("free.scl_d[%0d]", i), 32'(scl_d), 32'(exp_c >= CR));
    end

    // ---------------- stretching on: held at 4 for 5 low samples ----------------
    wait_cnt(0, 4);
    add_n(5, 1'b1, 4, 1'b0);
    add(1'b0, 5, 1'b0);
    add(1'b0, 6, 1'b0);
    add(1'b0, 7, 1'b0);
    add(1'b0, 0, 1'b0);
    apply(0, "stretch_on");

    // ---------------- stretching off: counter ignores the low ----------------
    wait_cnt(1, 4);
    add(1'b1, 5, 1'b0);
    add(1'b1, 6, 1'b0);
    add(1'b1, 7, 1'b0);
    add(1'b1, 0, 1'b0);
    add(1'b1, 1, 1'b0);
    add(1'b0, 2, 1'b0);
    add(1'b0, 3, 1'b0);
    apply(1, "stretch_off");

    // ---------------- multi-master on: low at 6 restarts period ----------------
    wait_cnt(2, 6);
    ext_c = 1'b1;
    tick();
    check("mm_on.cnt_restart", 32'(cnt_c), 0);
    ext_c = 1'b0;
    #1;
    check("mm_on.scl_driven_low", 32'(scl_c), 0);
    tick();
    check("mm_on.cnt_next", 32'(cnt_c), 1);

    // ---------------- multi-master off: same pulse, counter goes 7 ----------------
    wait_cnt(0, 6);
    add(1'b1, 7, 1'b0);
    add(1'b0, 0, 1'b0);
    apply(0, "mm_off");

    // ---------------- bus clear: 25 low samples from counter 4 ----------------
    wait_cnt(0, 4);
    add_n(WE, 1'b1, 4, 1'b0);
    add_n(5, 1'b1, 4, 1'b1);
    add(1'b0, 5, 1'b0);
    add(1'b0, 6, 1'b0);
    apply(0, "bus_clear");

    // ---------------- reset with bus_clear active ----------------
    wait_cnt(0, 4);
    ext_a = 1'b1;
    for (int i = 0; i < WE + 2; i++) tick();
    check("rst_mid.bc_before", 32'(bc_a), 1);
    check("rst_mid.cnt_before", 32'(cnt_a), 4);
    reset = 1'b1;
    ext_a = 1'b0;
    tick();
    check("rst_mid.cnt", 32'(cnt_a), 0);
    check("rst_mid.bc", 32'(bc_a), 0);
    check("rst_mid.scl_released", 32'(scl_a), 1);
    reset = 1'b0;
    #1;
    check("rst_mid.scl_low_after", 32'(scl_a), 0);
    for (int i = 0; i < CE; i++) begin
      tick();
      check($sformatf("rst_mid.period[%0d]", i), 32'(cnt_a), 32'((i + 1) % CE));
    end

    // ---------------- push-pull: external low ignored ----------------
    wait_cnt(3, 4);
    add(1'b1, 5, 1'b0);
    add(1'b1, 6, 1'b0);
    add(1'b1, 7, 1'b0);
    add(1'b0, 0, 1'b0);
    apply(3, "push_pull");
    tick();
    check("push_pull.scl_low_phase", 32'(scl_d), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
